// File: rtl/bsg_tie_checker.sv
// bsg_tie_checker
//   Watches a bus that should hold a constant tie-off value. The bus is
//   treated as asynchronous and passes through a 2-flop synchronizer.
//   Mismatches are debounced: a run of debounce_p consecutive mismatch
//   cycles latches a sticky error. On that error the block captures the
//   mismatching bit positions and the lowest mismatching bit index.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | checking disabled, nothing counted
//   CHECK   | armed, bus matches the expected value
//   PENDING | mismatch run in progress, shorter than debounce_p
//   ERROR   | sticky error latched; only clr_i or reset leaves it
//
// Ports
//   clk_i          clock
//   reset_n_i      asynchronous active-low reset
//   en_i           checking enable
//   data_i         monitored bus (may be asynchronous)
//   clr_i          single-cycle clear of error state and counter
//   err_o          sticky error flag
//   err_mask_o     sticky OR of mismatching bit positions
//   first_idx_o    lowest mismatching bit index captured on error entry
//   mismatch_cnt_o saturating count of mismatch cycles
//   busy_o         high while in PENDING
module bsg_tie_checker #(
  parameter int                 width_p      = 64,
  parameter logic [width_p-1:0] expect_val_p = {width_p{1'b1}},
  parameter int                 debounce_p   = 2,
  parameter int                 cnt_width_p  = 16,
  localparam int                idx_w_lp     = (width_p > 1) ? $clog2(width_p) : 1,
  localparam int                run_w_lp     = $clog2(debounce_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   en_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   clr_i,
  output logic                   err_o,
  output logic [width_p-1:0]     err_mask_o,
  output logic [idx_w_lp-1:0]    first_idx_o,
  output logic [cnt_width_p-1:0] mismatch_cnt_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    PENDING = 2'd2,
    ERROR   = 2'd3
  } state_e;

  state_e                 state;
  logic [width_p-1:0]     s1;
  logic [width_p-1:0]     s2;
  logic [run_w_lp-1:0]    run;
  logic [width_p-1:0]     mm;
  logic                   mismatch;
  logic [idx_w_lp-1:0]    low_idx;
  logic [run_w_lp-1:0]    run_inc;
  logic [cnt_width_p-1:0] cnt_inc;

  assign mm       = s2 ^ expect_val_p;
  assign mismatch = |mm;
  assign run_inc  = run + run_w_lp'(1);
  assign cnt_inc  = (&mismatch_cnt_o) ? mismatch_cnt_o
                                      : mismatch_cnt_o + cnt_width_p'(1);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    low_idx = '0;
    for (int i = width_p - 1; i >= 0; i--) begin
      if (mm[i]) low_idx = idx_w_lp'(i);
    end
  end

  assign err_o  = (state == ERROR);
  assign busy_o = (state == PENDING);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1             <= expect_val_p;
      s2             <= expect_val_p;
      state          <= IDLE;
      run            <= '0;
      err_mask_o     <= '0;
      first_idx_o    <= '0;
      mismatch_cnt_o <= '0;
    end else begin
      s1 <= data_i;
      s2 <= s1;
      if (clr_i) begin
        // A mismatch in the clear cycle is dropped, not counted.
        state          <= en_i ? CHECK : IDLE;
        run            <= '0;
        err_mask_o     <= '0;
        first_idx_o    <= '0;
        mismatch_cnt_o <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (en_i) state <= CHECK;
          end
          CHECK: begin
            if (!en_i) begin
              state <= IDLE;
            end else if (mismatch) begin
              mismatch_cnt_o <= cnt_inc;
              if (debounce_p == 1) begin
                state       <= ERROR;
                run         <= '0;
                err_mask_o  <= mm;
                first_idx_o <= low_idx;
              end else begin
                state <= PENDING;
                run   <= run_w_lp'(1);
              end
            end
          end
          PENDING: begin
            if (!en_i) begin
              state <= IDLE;
              run   <= '0;
            end else if (mismatch) begin
              mismatch_cnt_o <= cnt_inc;
              if (run_inc == run_w_lp'(debounce_p)) begin
                state       <= ERROR;
                run         <= '0;
                err_mask_o  <= mm;
                first_idx_o <= low_idx;
              end else begin
                run <= run_inc;
              end
            end else begin
              state <= CHECK;
              run   <= '0;
            end
          end
          ERROR: begin
            if (mismatch) begin
              mismatch_cnt_o <= cnt_inc;
              err_mask_o     <= err_mask_o | mm;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bsg_tie_checker.sv
module tb_bsg_tie_checker;

  localparam logic [63:0] ALL   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] BIT4  = 64'hFFFF_FFFF_FFFF_FFEF;
  localparam logic [63:0] BIT49 = 64'hFFFF_FFFF_FFFF_FDEF;
  localparam logic [63:0] B63   = 64'h7FFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [63:0] data;
  logic        clr;

  logic        err;
  logic [63:0] mask;
  logic [5:0]  idx;
  logic [15:0] cnt;
  logic        busy;

  logic        err_s;
  logic [63:0] mask_s;
  logic [5:0]  idx_s;
  logic [3:0]  cnt_s;
  logic        busy_s;

  int checks   = 0;
  int failures = 0;

  bsg_tie_checker dut (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .data_i(data), .clr_i(clr),
    .err_o(err), .err_mask_o(mask), .first_idx_o(idx),
    .mismatch_cnt_o(cnt), .busy_o(busy)
  );

  bsg_tie_checker #(.cnt_width_p(4)) dut_sat (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .data_i(data), .clr_i(clr),
    .err_o(err_s), .err_mask_o(mask_s), .first_idx_o(idx_s),
    .mismatch_cnt_o(cnt_s), .busy_o(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; data = ALL;
    #12;
    checks++;
    if (err !== 1'b0 || mask !== 64'd0 || idx !== 6'd0 || cnt !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: err=%b mask=%h idx=%0d cnt=%0d busy=%b, required all zero",
               err, mask, idx, cnt, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_clean_bus();
    int busy_seen = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (busy === 1'b1) busy_seen++;
    end
    checks++;
    if (err !== 1'b0 || cnt !== 16'd0) begin
      failures++;
      $display("FAIL clean_bus: err=%b cnt=%0d, required err=0 cnt=0", err, cnt);
    end
    checks++;
    if (busy_seen !== 0) begin
      failures++;
      $display("FAIL clean_busy: busy cycles=%0d, required 0", busy_seen);
    end
  endtask

  task automatic test_glitch();
    int busy_cycles = 0;
    @(negedge clk);
    data = B63;
    @(negedge clk);
    data = ALL;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (busy === 1'b1) busy_cycles++;
    end
    checks++;
    if (busy_cycles !== 1) begin
      failures++;
      $display("FAIL glitch_busy: busy cycles=%0d, required 1", busy_cycles);
    end
    checks++;
    if (err !== 1'b0 || cnt !== 16'd1) begin
      failures++;
      $display("FAIL glitch_count: err=%b cnt=%0d, required err=0 cnt=1", err, cnt);
    end
  endtask

  task automatic test_error_latency();
    do_clr();
    @(negedge clk);
    data = BIT4;
    step(3);  // edges E, E+1, E+2
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL latency_pending: err=%b busy=%b after E+2, required err=0 busy=1", err, busy);
    end
    step(1);  // E+3
    checks++;
    if (err !== 1'b1 || idx !== 6'd4 || mask !== 64'h10 || cnt !== 16'd2) begin
      failures++;
      $display("FAIL error_entry: err=%b idx=%0d mask=%h cnt=%0d, required 1 4 10 2",
               err, idx, mask, cnt);
    end
  endtask

  task automatic test_mask_and_clr();
    @(negedge clk);
    data = BIT49;
    step(3);
    checks++;
    if (err !== 1'b1 || mask !== 64'h210 || idx !== 6'd4) begin
      failures++;
      $display("FAIL mask_accum: err=%b mask=%h idx=%0d, required 1 210 4", err, mask, idx);
    end
    do_clr();
    checks++;
    if (err !== 1'b0 || mask !== 64'd0 || idx !== 6'd0 || cnt !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_wins: err=%b mask=%h idx=%0d cnt=%0d busy=%b, required all zero",
               err, mask, idx, cnt, busy);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    data = ALL;
    step(4);
    do_clr();
    step(2);
    checks++;
    if (cnt !== 16'd0 || cnt_s !== 4'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL sat_start: cnt=%0d cnt_s=%0d err=%b, required 0 0 0", cnt, cnt_s, err);
    end
    @(negedge clk);
    data = BIT4;
    step(40);
    checks++;
    if (cnt_s !== 4'd15) begin
      failures++;
      $display("FAIL sat_cnt: cnt_s=%0d, required 15", cnt_s);
    end
    checks++;
    if (cnt !== 16'd38) begin
      failures++;
      $display("FAIL wide_cnt: cnt=%0d, required 38", cnt);
    end
  endtask

  task automatic test_reset_mid_pending();
    int waited = 0;
    @(negedge clk);
    data = ALL;
    step(4);
    do_clr();
    @(negedge clk);
    data = BIT4;
    step(1);
    while (busy !== 1'b1 && waited < 10) begin
      step(1);
      waited++;
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL pending_reach: busy=%b, required 1 within budget", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0 || mask !== 64'd0 || idx !== 6'd0 || cnt !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: err=%b mask=%h idx=%0d cnt=%0d busy=%b, required all zero",
               err, mask, idx, cnt, busy);
    end
    data = ALL;
    @(negedge clk);
    rst_n = 1'b1;
    step(10);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || cnt !== 16'd0) begin
      failures++;
      $display("FAIL post_reset: err=%b busy=%b cnt=%0d, required 0 0 0", err, busy, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clean_bus();
    test_glitch();
    test_error_latency();
    test_mask_and_clr();
    test_saturate();
    test_reset_mid_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_tie_checker.md
Name: bsg_tie_checker

Overview:
- Monitors a bus that the design expects to hold a constant tie-off value; default expected value is all-ones.
- Debounces mismatches and latches a sticky error with diagnostic capture.
- Sits beside tie-off drivers on configuration and strap buses for DFT and bring-up visibility.
- Input is treated as asynchronous and passes through a 2-flop synchronizer.

Parameters:
- width_p, 64, width of monitored bus.
- expect_val_p, all-ones (width_p bits), expected constant value.
- debounce_p, 2, consecutive mismatch cycles (>=1) required to set error.
- cnt_width_p, 16, width of saturating mismatch-cycle counter.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset. Asynchronous, active-low.
- en_i  in  1  checking enable.
- data_i  in  width_p  monitored bus, may be asynchronous.
- clr_i  in  1  single-cycle request; clears error state and counter.
- err_o  out  1  sticky error flag.
- err_mask_o  out  width_p  sticky OR of mismatching bit positions.
- first_idx_o  out  $clog2(width_p)  lowest mismatching bit index when error set.
- mismatch_cnt_o  out  cnt_width_p  saturating count of mismatch cycles.
- busy_o  out  1  high in PENDING state.

Behaviour:
- Reset (async assert, sync deassert by clocking):
  - sync flops s1 and s2 load expect_val_p.
  - FSM = IDLE; run counter = 0.
  - err_o = 0, err_mask_o = 0, first_idx_o = 0, mismatch_cnt_o = 0, busy_o = 0.
- Synchronizer runs every cycle regardless of en_i: s1 <= data_i, s2 <= s1.
- Mismatch vector mm = s2 XOR expect_val_p; mismatch when mm != 0.
- FSM states: IDLE, CHECK, PENDING, ERROR.
  - IDLE: en_i=1 -> CHECK. No counting.
  - CHECK: mismatch -> run = 1, mismatch_cnt++.
    - debounce_p == 1 -> ERROR directly.
    - else -> PENDING.
  - PENDING (busy_o = 1), each mismatch cycle: run++ and mismatch_cnt++.
    - When run reaches debounce_p -> ERROR.
    - No mismatch -> run = 0, back to CHECK.
    - en_i=0 -> IDLE, run = 0.
  - ERROR: err_o = 1.
    - Each mismatch cycle: mismatch_cnt++ and err_mask_o |= mm.
    - en_i has no effect; only clr_i or reset leaves ERROR.
- On entering ERROR:
  - err_mask_o <= mm.
  - first_idx_o <= lowest set bit index of mm.
  - first_idx_o holds until clr_i.
- Latency: a persistent mismatch on data_i before rising edge E is in s2 after E+1. err_o is high after edge E+1+debounce_p.
- Glitch filter: any mismatch run shorter than debounce_p cycles never sets err_o, but is still counted in mismatch_cnt_o.
- mismatch_cnt_o saturates at 2^cnt_width_p-1 with no wrap. It counts only when the FSM is not in IDLE.
- clr_i (sampled at edge):
  - err_o, err_mask_o, first_idx_o, mismatch_cnt_o, run <= 0.
  - FSM -> CHECK if en_i, else IDLE.
  - clr_i wins over a mismatch in the same cycle; that cycle's mismatch is discarded (not counted).
- en_i falls in CHECK or PENDING -> IDLE next edge. The counter holds its value.
- Reset asserted mid-operation: all state returns to reset values immediately.

Test Plan:
1. width_p=64, debounce_p=2, en_i=1, data_i held all-ones for 100 cycles -> err_o=0, mismatch_cnt_o=0, busy_o never 1.
2. data_i=0xFFFF_FFFF_FFFF_FFEF held from edge E -> err_o rises after edge E+3, first_idx_o=4, err_mask_o=0x10, mismatch_cnt_o=2 at that point.
3. Single-cycle glitch data_i[63]=0 -> busy_o pulses 1 cycle, err_o stays 0, mismatch_cnt_o=1.
4. In ERROR from scenario 2, drive bit 9 low as well -> err_mask_o=0x210, first_idx_o stays 4. Pulse clr_i concurrent with the mismatch -> all outputs 0 next cycle, counter 0.
5. cnt_width_p=4, persistent mismatch 40 cycles -> mismatch_cnt_o saturates at 15.
6. Assert reset_n_i=0 asynchronously mid-PENDING (between edges) -> outputs zero immediately. After release with data_i all-ones, no error.
